// File: rtl/regfile_sb.sv
// Decode-stage register file with a per-register pending-write scoreboard and RAW stall generation.
// Optional macro RF_WB_BYPASS_EN enables same-cycle writeback-to-read forwarding.
module regfile_sb #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned REG_NUM        = 32,
    parameter int unsigned ADDR_SIZE      = 5,
    parameter int unsigned NUM_RD         = 2,
    parameter int unsigned PEND_BITS      = 2,
    parameter int unsigned STALL_CNT_BITS = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_RD-1:0]           D_ren,
    input  logic [NUM_RD*ADDR_SIZE-1:0] D_rs,
    input  logic                        D_issue,
    input  logic                        D_wen,
    input  logic [ADDR_SIZE-1:0]        D_rd,
    input  logic                        WB_we,
    input  logic [ADDR_SIZE-1:0]        WB_rd,
    input  logic [XLEN-1:0]             WB_data,
    output logic [NUM_RD*XLEN-1:0]      D_rdata,
    output logic [NUM_RD-1:0]           D_rdy,
    output logic                        D_stall,
    output logic                        WB_err,
    output logic [STALL_CNT_BITS-1:0]   STALL_CNT
);

    localparam logic [PEND_BITS-1:0] PEND_MAX = '1;

    logic [XLEN-1:0]      regs [REG_NUM];
    logic [PEND_BITS-1:0] pend [REG_NUM];
    logic [NUM_RD-1:0]    rdy;
    logic                 stall;
    logic                 accept;
    logic                 d_hit;
    logic                 d_full;
    logic                 wb_hit;
    logic [REG_NUM-1:0]   inc;
    logic [REG_NUM-1:0]   dec;

    // x0 and indices past the implemented registers are never tracked or written
    function automatic logic valid_idx(input logic [ADDR_SIZE-1:0] a);
        return (a != '0) && (32'(a) < REG_NUM);
    endfunction

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_SIZE-1:0] rs;
        logic [PEND_BITS-1:0] p;
        logic                 hit;
        logic                 busy;
        logic                 resolved;

        assign rs   = D_rs[i*ADDR_SIZE +: ADDR_SIZE];
        assign hit  = valid_idx(rs);
        assign p    = hit ? pend[rs] : '0;
        assign busy = D_ren[i] && (p != '0);
`ifdef RF_WB_BYPASS_EN
        logic fwd;
        assign fwd      = hit && WB_we && (WB_rd == rs);
        // only the last outstanding write can be satisfied by the forwarded value
        assign resolved = busy && (p == PEND_BITS'(1)) && fwd;
        assign D_rdata[i*XLEN +: XLEN] = !hit ? '0 : (fwd ? WB_data : regs[rs]);
`else
        assign resolved = 1'b0;
        assign D_rdata[i*XLEN +: XLEN] = hit ? regs[rs] : '0;
`endif
        assign rdy[i] = !busy || resolved;
    end

    assign d_hit   = valid_idx(D_rd);
    assign d_full  = d_hit && (pend[D_rd] == PEND_MAX);
    assign wb_hit  = WB_we && valid_idx(WB_rd);
    assign stall   = D_issue && (!(&rdy) || (D_wen && d_full));
    assign accept  = D_issue && !stall;
    assign D_rdy   = rdy;
    assign D_stall = stall;

    // per-register scoreboard increment/decrement requests
    always_comb begin
        inc = '0;
        dec = '0;
        for (int r = 1; r < REG_NUM; r++) begin
            inc[r] = accept && D_wen && d_hit && (D_rd == ADDR_SIZE'(r));
            dec[r] = wb_hit && (WB_rd == ADDR_SIZE'(r)) && (pend[r] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < REG_NUM; r++) begin
                regs[r] <= '0;
                pend[r] <= '0;
            end
            WB_err    <= 1'b0;
            STALL_CNT <= '0;
        end else begin
            if (wb_hit) begin
                regs[WB_rd] <= WB_data;
                if (pend[WB_rd] == '0) begin
                    WB_err <= 1'b1;
                end
            end
            if (stall && (STALL_CNT != '1)) begin
                STALL_CNT <= STALL_CNT + STALL_CNT_BITS'(1);
            end
            for (int r = 1; r < REG_NUM; r++) begin
                if (inc[r] && !dec[r]) begin
                    pend[r] <= pend[r] + PEND_BITS'(1);
                end else if (dec[r] && !inc[r]) begin
                    pend[r] <= pend[r] - PEND_BITS'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized self-checking bench for regfile_sb against a spec-level scoreboard model.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;
    localparam int NREG = 32;
    localparam int PMAX = 3;
    localparam int CMAX = 65535;
`ifdef RF_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                 clk;
    logic                 rst;
    logic [NRD-1:0]       D_ren;
    logic [NRD*AW-1:0]    D_rs;
    logic                 D_issue;
    logic                 D_wen;
    logic [AW-1:0]        D_rd;
    logic                 WB_we;
    logic [AW-1:0]        WB_rd;
    logic [XLEN-1:0]      WB_data;
    logic [NRD*XLEN-1:0]  D_rdata;
    logic [NRD-1:0]       D_rdy;
    logic                 D_stall;
    logic                 WB_err;
    logic [15:0]          STALL_CNT;

    regfile_sb dut (
        .clk(clk), .rst(rst), .D_ren(D_ren), .D_rs(D_rs), .D_issue(D_issue),
        .D_wen(D_wen), .D_rd(D_rd), .WB_we(WB_we), .WB_rd(WB_rd), .WB_data(WB_data),
        .D_rdata(D_rdata), .D_rdy(D_rdy), .D_stall(D_stall), .WB_err(WB_err),
        .STALL_CNT(STALL_CNT)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [XLEN-1:0] m_regs [NREG];
    int              m_pend [NREG];
    bit              m_err;
    int              m_cnt;
    bit              exp_stall;
    int              vectors;
    int              miscompares;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // expected outputs from the architectural state and the current inputs
    task automatic settle();
        logic [NRD*XLEN-1:0] e_rdata;
        logic [NRD-1:0]      e_rdy;
        int                  rs;
        int                  p;
        bit                  fwd;
        #2;
        e_rdata = '0;
        e_rdy   = '1;
        for (int i = 0; i < NRD; i++) begin
            rs = int'(D_rs[i*AW +: AW]);
            if (rs != 0 && rs < NREG) begin
                p   = m_pend[rs];
                fwd = BYP && WB_we && (int'(WB_rd) == rs);
                e_rdata[i*XLEN +: XLEN] = fwd ? WB_data : m_regs[rs];
                if (D_ren[i] && p > 0 && !(fwd && p == 1)) e_rdy[i] = 1'b0;
            end
        end
        exp_stall = D_issue && ((e_rdy != '1) || (D_wen && D_rd != 0 && m_pend[D_rd] == PMAX));
        chk("rdata", 64'(D_rdata), 64'(e_rdata));
        chk("rdy", 64'(D_rdy), 64'(e_rdy));
        chk("stall", 64'(D_stall), 64'(exp_stall));
        chk("wb_err", 64'(WB_err), 64'(m_err));
        chk("stall_cnt", 64'(STALL_CNT), 64'(m_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                m_regs[r] = '0;
                m_pend[r] = 0;
            end
            m_err = 1'b0;
            m_cnt = 0;
        end else begin
            if (WB_we && WB_rd != 0) begin
                m_regs[WB_rd] = WB_data;
                if (m_pend[WB_rd] == 0) m_err = 1'b1;
                else m_pend[WB_rd]--;
            end
            if (D_issue && !exp_stall && D_wen && D_rd != 0) m_pend[D_rd]++;
            if (exp_stall && m_cnt < CMAX) m_cnt++;
        end
        #1;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic idle();
        rst = 0; D_ren = '0; D_rs = '0; D_issue = 0; D_wen = 0; D_rd = '0;
        WB_we = 0; WB_rd = '0; WB_data = '0;
    endtask

    function automatic logic [AW-1:0] rnd_idx();
        if ($urandom_range(0, 9) == 0) return AW'($urandom);
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin
        int k;
        int j;
        vectors = 0;
        miscompares = 0;
        exp_stall = 1'b0;
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;

        // reset state: x0 on port 0, x5 on port 1
        D_ren = 2'b11; D_rs = {5'd5, 5'd0};
        settle();
        chk("lit_reset_rdata", 64'(D_rdata), 64'h0);
        chk("lit_reset_rdy", 64'(D_rdy), 64'h3);
        chk("lit_reset_stall", 64'(D_stall), 64'h0);
        chk("lit_reset_cnt", 64'(STALL_CNT), 64'h0);
        chk("lit_reset_err", 64'(WB_err), 64'h0);
        tick();

        // unexpected writeback sets the sticky error
        idle(); WB_we = 1; WB_rd = 7; WB_data = 32'hDEADBEEF; D_ren = 2'b01; D_rs = {5'd0, 5'd7};
        step();
        WB_we = 0;
        settle();
        chk("lit_x7_data", 64'(D_rdata[31:0]), 64'hDEADBEEF);
        chk("lit_err_set", 64'(WB_err), 64'h1);
        tick();
        rst = 1;
        step();
        rst = 0;
        settle();
        chk("lit_err_clr", 64'(WB_err), 64'h0);
        chk("lit_x7_clr", 64'(D_rdata[31:0]), 64'h0);
        tick();

        // RAW hazard on x3
        idle(); D_issue = 1; D_wen = 1; D_rd = 3;
        settle();
        chk("lit_issue3", 64'(D_stall), 64'h0);
        tick();
        D_wen = 0; D_ren = 2'b01; D_rs = {5'd0, 5'd3};
        settle();
        chk("lit_raw_stall0", 64'(D_stall), 64'h1);
        chk("lit_raw_cnt0", 64'(STALL_CNT), 64'h0);
        tick();
        settle();
        chk("lit_raw_stall1", 64'(D_stall), 64'h1);
        chk("lit_raw_cnt1", 64'(STALL_CNT), 64'h1);
        tick();
        WB_we = 1; WB_rd = 3; WB_data = 32'h1234;
        settle();
        chk("lit_wb_cycle_stall", 64'(D_stall), BYP ? 64'h0 : 64'h1);
        if (BYP) chk("lit_wb_fwd", 64'(D_rdata[31:0]), 64'h1234);
        tick();
        WB_we = 0;
        settle();
        chk("lit_after_wb_stall", 64'(D_stall), 64'h0);
        chk("lit_after_wb_data", 64'(D_rdata[31:0]), 64'h1234);
        chk("lit_after_wb_cnt", 64'(STALL_CNT), BYP ? 64'd2 : 64'd3);
        tick();

        // WAW: two writes in flight to x9
        idle(); D_issue = 1; D_wen = 1; D_rd = 9;
        step();
        step();
        D_wen = 0; D_ren = 2'b01; D_rs = {5'd0, 5'd9};
        WB_we = 1; WB_rd = 9; WB_data = 32'h111;
        settle();
        chk("lit_waw_stall", 64'(D_stall), 64'h1);
        tick();
        WB_data = 32'h222;
        step();
        WB_we = 0;
        settle();
        chk("lit_waw_go", 64'(D_stall), 64'h0);
        chk("lit_waw_data", 64'(D_rdata[31:0]), 64'h222);
        tick();

        // pending counter saturation on x4
        idle(); D_issue = 1; D_wen = 1; D_rd = 4;
        step();
        step();
        step();
        WB_we = 1; WB_rd = 4; WB_data = 32'h44;
        settle();
        chk("lit_full_stall", 64'(D_stall), 64'h1);
        tick();
        WB_we = 0;
        settle();
        chk("lit_full_accept", 64'(D_stall), 64'h0);
        tick();

        // reset while x3 has two writes pending and an issue is active
        idle(); D_issue = 1; D_wen = 1; D_rd = 3;
        step();
        step();
        rst = 1;
        step();
        rst = 0; D_wen = 0; D_ren = 2'b11; D_rs = {5'd4, 5'd3};
        settle();
        chk("lit_rst_stall", 64'(D_stall), 64'h0);
        chk("lit_rst_rdy", 64'(D_rdy), 64'h3);
        chk("lit_rst_data", 64'(D_rdata[31:0]), 64'h0);
        chk("lit_rst_cnt", 64'(STALL_CNT), 64'h0);
        tick();

        // randomized traffic, writebacks biased towards registers with writes in flight
        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 299) == 0);
            D_ren   = NRD'($urandom);
            for (int i = 0; i < NRD; i++) D_rs[i*AW +: AW] = rnd_idx();
            D_issue = 1'($urandom_range(0, 1));
            D_wen   = 1'($urandom_range(0, 1));
            D_rd    = rnd_idx();
            WB_we   = 1'($urandom_range(0, 1));
            WB_rd   = rnd_idx();
            WB_data = $urandom;
            if ($urandom_range(0, 7) != 0) begin
                k = $urandom_range(0, 6);
                for (int t = 0; t < 7; t++) begin
                    j = (k + t) % 7 + 1;
                    if (m_pend[j] > 0) begin
                        WB_rd = AW'(j);
                        break;
                    end
                end
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
